// File: rtl/bram16_pkg.sv
// Shared constants for bram16 and its command-driven port master.
package bram16_pkg;
  localparam int BRAM_ADDR_W = 9;
  localparam int BRAM_DATA_W = 16;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR       = 3'd1;
  localparam logic [2:0] S_RD_ISSUE = 3'd2;
  localparam logic [2:0] S_RD_CAP   = 3'd3;
  localparam logic [2:0] S_FILL     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
endpackage

// File: rtl/bram16_master.sv
// Sequences one bram16 port for single read/write and range-fill commands,
// returning one completion pulse per command.
module bram16_master
  import bram16_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              en_q, en_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    en_d        = en_q;
    we_d        = we_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        case (cmd_op)
          OP_READ: begin
            state_d = S_RD_ISSUE;
            en_d    = 1'b1;
            we_d    = 1'b0;
            addr_d  = cmd_addr;
          end
          OP_WRITE: begin
            state_d = S_WR;
            en_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = cmd_addr;
            din_d   = cmd_data;
          end
          OP_FILL: begin
            addr_d = cmd_addr;
            din_d  = cmd_data;
            if (cmd_len == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FILL;
              en_d    = 1'b1;
              we_d    = 1'b1;
              rem_d   = cmd_len - (ADDR_W+1)'(1);
            end
          end
          default: state_d = S_DONE;
        endcase
      end
      S_RD_ISSUE: begin
        en_d    = 1'b0;
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        rsp_data_d  = mem_dout;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_WR: begin
        en_d        = 1'b0;
        we_d        = 1'b0;
        rsp_data_d  = '0;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_FILL: begin
        // rem counts writes still to issue after the current one
        if (rem_q == '0) begin
          en_d    = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - (ADDR_W+1)'(1);
        end
      end
      S_DONE: begin
        rsp_data_d  = '0;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        we_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) & ~rst;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
endmodule
